// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: registered main entry plus one-entry skid buffer, with x0 forcing and
// writeback patching of operands. Optional macro ID_EX_BYPASS_EN enables capture bypass and held-entry patching.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic [XLEN-1:0]   rd1_data,
  input  logic [XLEN-1:0]   rd2_data,
  input  logic [4:0]        rd_addr,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [4:0]        out_rs1_addr,
  output logic [4:0]        out_rs2_addr,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  typedef struct packed {
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  state_t r_state;
  entry_t r_main;
  entry_t r_skid;
  logic   r_main_vld;
  logic   r_skid_vld;
  logic   r_in_ready;

  entry_t w_in_ent;
  entry_t w_main_pat;
  entry_t w_skid_pat;
  logic   w_accept;
  logic   w_issue;

`ifdef ID_EX_BYPASS_EN
  // x0 is hard zero; otherwise a matching writeback overrides the given value.
  function automatic logic [XLEN-1:0] resolve(input logic [4:0] a, input logic [XLEN-1:0] v,
                                              input logic we, input logic [4:0] wa,
                                              input logic [XLEN-1:0] wd);
    if (a == 5'd0) return '0;
    if (we && (wa == a)) return wd;
    return v;
  endfunction
`else
  function automatic logic [XLEN-1:0] resolve_raw(input logic [4:0] a, input logic [XLEN-1:0] v);
    return (a == 5'd0) ? '0 : v;
  endfunction

  logic w_unused;
  assign w_unused = ^{wb_we, wb_addr, wb_data};
`endif

  always_comb begin
    w_in_ent          = '0;
    w_in_ent.pc       = pc_in;
    w_in_ent.imm      = imm_in;
    w_in_ent.rs1_addr = rs1_addr;
    w_in_ent.rs2_addr = rs2_addr;
    w_in_ent.rd       = rd_addr;
    w_in_ent.ctrl     = ctrl_in;
    w_main_pat        = r_main;
    w_skid_pat        = r_skid;
`ifdef ID_EX_BYPASS_EN
    w_in_ent.rs1_val   = resolve(rs1_addr, rd1_data, wb_we, wb_addr, wb_data);
    w_in_ent.rs2_val   = resolve(rs2_addr, rd2_data, wb_we, wb_addr, wb_data);
    w_main_pat.rs1_val = resolve(r_main.rs1_addr, r_main.rs1_val, wb_we, wb_addr, wb_data);
    w_main_pat.rs2_val = resolve(r_main.rs2_addr, r_main.rs2_val, wb_we, wb_addr, wb_data);
    w_skid_pat.rs1_val = resolve(r_skid.rs1_addr, r_skid.rs1_val, wb_we, wb_addr, wb_data);
    w_skid_pat.rs2_val = resolve(r_skid.rs2_addr, r_skid.rs2_val, wb_we, wb_addr, wb_data);
`else
    w_in_ent.rs1_val   = resolve_raw(rs1_addr, rd1_data);
    w_in_ent.rs2_val   = resolve_raw(rs2_addr, rd2_data);
`endif
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_issue  = r_main_vld & ex_ready;

  // Held entries track writebacks every cycle; state moves only on accept/issue/flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_main <= w_main_pat;
      r_skid <= w_skid_pat;
      if (flush) begin
        r_state    <= ST_EMPTY;
        r_main_vld <= 1'b0;
        r_skid_vld <= 1'b0;
        r_in_ready <= 1'b1;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_accept) begin
              r_main     <= w_in_ent;
              r_main_vld <= 1'b1;
              r_state    <= ST_FULL;
            end
          end
          ST_FULL: begin
            if (w_accept && w_issue) begin
              r_main <= w_in_ent;
            end else if (w_accept) begin
              r_skid     <= w_in_ent;
              r_skid_vld <= 1'b1;
              r_in_ready <= 1'b0;
              r_state    <= ST_SKID;
            end else if (w_issue) begin
              r_main_vld <= 1'b0;
              r_state    <= ST_EMPTY;
            end
          end
          ST_SKID: begin
            if (w_issue) begin
              r_main     <= w_skid_pat;
              r_skid_vld <= 1'b0;
              r_in_ready <= 1'b1;
              r_state    <= ST_FULL;
            end
          end
          default: begin
            r_state    <= ST_EMPTY;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_main_vld;
  assign out_rs1_val  = r_main.rs1_val;
  assign out_rs2_val  = r_main.rs2_val;
  assign out_rs1_addr = r_main.rs1_addr;
  assign out_rs2_addr = r_main.rs2_addr;
  assign out_rd       = r_main.rd;
  assign out_pc       = r_main.pc;
  assign out_imm      = r_main.imm;
  assign out_ctrl     = r_main.ctrl;

endmodule
